// File: rtl/data_memory_bytelane_if.sv
// Core-side access bus of the byte-lane data memory.
// The core (master) drives address, size, store data and enables;
// the memory (slave) returns load data, the stall flag and the fault flag.
interface data_memory_bytelane_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  WE;
  logic [1:0]            SIZE;
  logic                  UNSIGNED;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic                  BUSY;
  logic                  MISALIGN;

  modport master (
    output WE, SIZE, UNSIGNED, A, WD,
    input  RD, BUSY, MISALIGN
  );

  modport slave (
    input  WE, SIZE, UNSIGNED, A, WD,
    output RD, BUSY, MISALIGN
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Byte-addressed data memory for the single-cycle MIPS datapath.
// Sized stores (SB/SH/SW), sign/zero-extending loads (LB/LBU/LH/LHU/LW),
// misalignment detection and a post-reset clear sequencer that stalls
// the core through BUSY while it zeroes the array one word per cycle.
//
// Clear FSM states:
//   state   | meaning
//   S_IDLE  | array usable; core loads and stores are serviced
//   S_CLEAR | one word zeroed per cycle from clr_ptr; BUSY high, core gated
module data_memory_bytelane #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int TEST_ADDR  = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  data_memory_bytelane_if.slave     bus,
  output logic [DATA_WIDTH/2-1:0]   test_value
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t                  state;
  logic [AW-1:0]           clr_ptr;
  logic                    busy;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [AW-1:0]           word_idx;
  logic [1:0]              lane;
  logic                    misalign;
  logic                    store_ok;
  logic                    clear_we;
  logic [LANES-1:0]        lane_we;
  logic [DATA_WIDTH-1:0]   wd_rep;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [DATA_WIDTH-1:0]   rd_ext;
  logic                    unused_addr_bits;

  // Address bits above the word index are ignored, so the array aliases
  // every 4*DEPTH bytes.
  assign word_idx         = bus.A[AW+1:2];
  assign lane             = bus.A[1:0];
  assign unused_addr_bits = ^bus.A[DATA_WIDTH-1:AW+2];

  // Fault flag for the presented access, independent of WE.
  always_comb begin
    misalign = 1'b0;
    unique case (bus.SIZE)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = bus.A[0];
      SZ_WORD: misalign = (bus.A[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // A store lands only when legal and the clear sequencer is neither
  // running nor being restarted this cycle.
  assign store_ok = bus.WE && !misalign && !busy && !RST;
  assign clear_we = (state == S_CLEAR) && !RST;

  // Lane enables and lane-replicated store data for the sized store.
  always_comb begin
    lane_we = '0;
    wd_rep  = bus.WD;
    unique case (bus.SIZE)
      SZ_BYTE: begin
        lane_we[lane] = 1'b1;
        wd_rep        = {LANES{bus.WD[7:0]}};
      end
      SZ_HALF: begin
        lane_we = bus.A[1] ? 4'b1100 : 4'b0011;
        wd_rep  = {2{bus.WD[15:0]}};
      end
      SZ_WORD: begin
        lane_we = '1;
        wd_rep  = bus.WD;
      end
      default: begin
        lane_we = '0;
        wd_rep  = bus.WD;
      end
    endcase
  end

  // Clear sequencer: reset (re)starts the sweep, which walks every word
  // once and then releases BUSY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      unique case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          busy <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: clearing takes priority over core stores, which only
  // touch the addressed lanes.
  always_ff @(posedge CLK) begin
    if (clear_we) begin
      mem[clr_ptr] <= '0;
    end else if (store_ok) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) begin
          mem[word_idx][8*l +: 8] <= wd_rep[8*l +: 8];
        end
      end
    end
  end

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[8*lane +: 8];
  assign rd_half = bus.A[1] ? rd_word[31:16] : rd_word[15:0];

  // Load extension; word loads pass the raw word regardless of UNSIGNED.
  always_comb begin
    rd_ext = '0;
    unique case (bus.SIZE)
      SZ_BYTE: rd_ext = bus.UNSIGNED ? {24'h0, rd_byte}
                                     : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_ext = bus.UNSIGNED ? {16'h0, rd_half}
                                     : {{16{rd_half[15]}}, rd_half};
      SZ_WORD: rd_ext = rd_word;
      default: rd_ext = '0;
    endcase
  end

  assign bus.RD       = (misalign || busy) ? '0 : rd_ext;
  assign bus.BUSY     = busy;
  assign bus.MISALIGN = misalign;

  assign test_value   = mem[TEST_ADDR][DATA_WIDTH/2-1:0];

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: clear-sequence timing, directed sized
// accesses, misalignment, wrap-around, BUSY gating and a randomised run
// against a byte-array reference model with a load scoreboard.
module tb_data_memory_bytelane;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] test_value;

  int errors = 0;
  int checks = 0;

  logic [7:0]  model [1024];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  data_memory_bytelane_if #(.DATA_WIDTH(32)) bus ();

  data_memory_bytelane #(
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .TEST_ADDR  (0)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .test_value (test_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a);
    int b;
    logic [7:0]  by;
    logic [15:0] hw;
    b = int'(a[9:0]);
    if (model_mis(size, a)) return 32'h0;
    case (size)
      2'b00: begin
        by = model[b];
        return uns ? {24'h0, by} : {{24{by[7]}}, by};
      end
      2'b01: begin
        hw = {model[b+1], model[b]};
        return uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
      end
      default: return {model[b+3], model[b+2], model[b+1], model[b]};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
    int b;
    int n;
    b = int'(a[9:0]);
    if (model_mis(size, a)) return;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) model[b+i] = wd[8*i +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
  endtask

  // Store issued while the memory is idle; the model follows it.
  task automatic do_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
    bus.WE = 1'b1; bus.SIZE = size; bus.UNSIGNED = 1'b0; bus.A = a; bus.WD = wd;
    model_store(size, a, wd);
    @(negedge clk);
    bus.WE = 1'b0;
  endtask

  task automatic sb_compare();
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    check(t, bus.RD, e);
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    bus.WE = 1'b0; bus.SIZE = size; bus.UNSIGNED = uns; bus.A = a; bus.WD = 32'h0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #2;
    sb_compare();
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.BUSY === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        uns;

    rst = 1'b1;
    bus.WE = 1'b0; bus.SIZE = 2'b10; bus.UNSIGNED = 1'b0; bus.A = 32'h0; bus.WD = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("busy_after_rst", 32'(bus.BUSY), 32'd1);
    count_busy(n);
    check("clear_len", n, 32'd256);
    model_clear();
    do_load("clr_lw_000", 2'b10, 1'b0, 32'h000, 32'h0);
    do_load("clr_lw_3fc", 2'b10, 1'b0, 32'h3FC, 32'h0);
    check("clr_test_value", 32'(test_value), 32'h0);

    // Byte lanes
    do_store(2'b10, 32'h010, 32'h11223344);
    do_store(2'b00, 32'h012, 32'h000000AB);
    do_load("lw_010", 2'b10, 1'b0, 32'h010, 32'h11AB3344);
    do_load("lb_012", 2'b00, 1'b0, 32'h012, 32'hFFFFFFAB);
    do_load("lbu_012", 2'b00, 1'b1, 32'h012, 32'h000000AB);
    do_load("lb_010", 2'b00, 1'b0, 32'h010, 32'h00000044);
    do_load("lw_uns_010", 2'b10, 1'b1, 32'h010, 32'h11AB3344);

    // Halfwords
    do_store(2'b01, 32'h022, 32'h00008001);
    do_load("lw_020", 2'b10, 1'b0, 32'h020, 32'h80010000);
    do_load("lh_022", 2'b01, 1'b0, 32'h022, 32'hFFFF8001);
    do_load("lhu_022", 2'b01, 1'b1, 32'h022, 32'h00008001);
    do_load("lh_020", 2'b01, 1'b0, 32'h020, 32'h00000000);

    // Misalignment
    do_store(2'b10, 32'h030, 32'h01020304);
    bus.WE = 1'b1; bus.SIZE = 2'b10; bus.A = 32'h031; bus.WD = 32'hDEADBEEF;
    #1;
    check("mis_sw_031", 32'(bus.MISALIGN), 32'd1);
    @(negedge clk);
    bus.WE = 1'b0;
    do_load("lw_030_kept", 2'b10, 1'b0, 32'h030, 32'h01020304);
    bus.SIZE = 2'b01; bus.A = 32'h033;
    #1;
    check("mis_lh_033", 32'(bus.MISALIGN), 32'd1);
    do_load("rd_lh_033", 2'b01, 1'b0, 32'h033, 32'h0);
    bus.SIZE = 2'b11; bus.A = 32'h010;
    #1;
    check("mis_size11", 32'(bus.MISALIGN), 32'd1);
    bus.SIZE = 2'b01; bus.A = 32'h012;
    #1;
    check("mis_lh_012", 32'(bus.MISALIGN), 32'd0);
    @(negedge clk);

    // Wrap-around
    do_store(2'b10, 32'h400, 32'hCAFEF00D);
    do_load("lw_wrap_000", 2'b10, 1'b0, 32'h000, 32'hCAFEF00D);
    check("tv_wrap", 32'(test_value), 32'h0000F00D);

    // Randomised accesses against the byte model
    for (int i = 0; i < 80; i++) begin
      sz  = 2'($urandom_range(0, 3));
      a   = $urandom;
      wd  = $urandom;
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 1) == 1) begin
        do_store(sz, a, wd);
      end else begin
        bus.SIZE = sz; bus.A = a;
        #1;
        check($sformatf("rnd_mis_%0d", i), 32'(bus.MISALIGN), 32'(model_mis(sz, a)));
        do_load($sformatf("rnd_ld_%0d", i), sz, uns, a, model_load(sz, uns, a));
      end
    end
    check("rnd_test_value", 32'(test_value), {16'h0, model[1], model[0]});

    // BUSY gating and clear restart
    do_store(2'b10, 32'h044, 32'h55AA55AA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("busy_rst2", 32'(bus.BUSY), 32'd1);
    check("tv_unwritten_at_rst", 32'(test_value), {16'h0, model[1], model[0]});
    do_load("lw_044_busy", 2'b10, 1'b0, 32'h044, 32'h0);
    for (int i = 1; i < 100; i++) @(negedge clk);
    check("busy_cycle100", 32'(bus.BUSY), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.WE = 1'b1; bus.SIZE = 2'b10; bus.A = 32'h040; bus.WD = 32'h12345678;
    n = 0;
    while (bus.BUSY === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 3) bus.WE = 1'b0;
    end
    bus.WE = 1'b0;
    check("clear_restart_len", n, 32'd256);
    model_clear();
    do_load("lw_040_gated", 2'b10, 1'b0, 32'h040, 32'h0);
    do_load("lw_044_cleared", 2'b10, 1'b0, 32'h044, 32'h0);
    check("tv_cleared", 32'(test_value), 32'h0);

    do_store(2'b01, 32'h002, 32'h0000BEEF);
    do_load("lhu_002_after", 2'b01, 1'b1, 32'h002, 32'h0000BEEF);
    check("tv_unaffected_hi", 32'(test_value), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Next-generation data memory for the single-cycle MIPS datapath.
- Byte-addressed and parametrised in depth.
- Supports sized stores (SB/SH/SW) and loads (LB/LBU/LH/LHU/LW) with sign or zero extension, and flags misaligned accesses.
- A hardware clear sequencer zeroes the array after reset and stalls the core via BUSY.
- Sits between the ALU result/RegFile read-data-2 and the write-back mux.

Parameters:
- DATA_WIDTH, 32, data word width in bits; fixed at 32 (four byte lanes).
- DEPTH, 256, number of 32-bit words; power of two, at least 4.
- TEST_ADDR, 0, word index driven onto test_value.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous active-high reset.
- WE  input  1  store enable.
- SIZE  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- UNSIGNED  input  1  load extension: 1 zero-extend, 0 sign-extend; ignored for word accesses.
- A  input  DATA_WIDTH  byte address.
- WD  input  DATA_WIDTH  store data, right-justified.
- RD  output  DATA_WIDTH  load data, extended, combinational.
- BUSY  output  1  clear sequence in progress; the core must stall while high.
- MISALIGN  output  1  combinational fault flag for the current access.
- test_value  output  DATA_WIDTH/2  bits [15:0] of word TEST_ADDR.

Behaviour:
- Addressing:
  - Word index = A[log2(DEPTH)+1 : 2]; byte lane = A[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
  - Lane 0 is bits [7:0] (little-endian).
- MISALIGN = 1 when any of the following holds; it is independent of WE:
  - SIZE = 11;
  - SIZE = 01 and A[0] = 1;
  - SIZE = 10 and A[1:0] != 00.
- Stores (posedge CLK, only when WE=1, MISALIGN=0, BUSY=0):
  - Byte: lane A[1:0] <= WD[7:0].
  - Half: lanes {A[1],1}:{A[1],0} <= WD[15:0].
  - Word: whole word <= WD.
  - Unaddressed lanes are unchanged.
  - A misaligned or BUSY store is dropped silently; the array is unchanged.
- Loads (combinational from A, SIZE, UNSIGNED and array contents):
  - Byte: selected lane, extended per UNSIGNED.
  - Half: selected lane pair, extended per UNSIGNED.
  - Word: raw word.
  - RD = 0 when MISALIGN=1 or BUSY=1.
  - Read-after-write: RD reflects a store from the cycle immediately after its posedge; there is no same-cycle bypass.
- Clear FSM, states IDLE and CLEAR, 8-bit-class pointer clr_ptr (log2(DEPTH) bits):
  - RST=1 at a posedge: state <= CLEAR, clr_ptr <= 0, BUSY=1. The array is not written in that cycle.
  - CLEAR with RST=0: mem[clr_ptr] <= 0, clr_ptr <= clr_ptr+1.
  - When clr_ptr = DEPTH-1 is written: state <= IDLE, BUSY <= 0.
  - BUSY is therefore high for exactly DEPTH posedges after the first posedge with RST=0.
  - RST reasserted mid-clear restarts the sequence from 0.
  - Core stores during CLEAR are ignored (clear has priority).
- Reset values:
  - BUSY=1 from the reset posedge.
  - RD=0 and test_value=0 once clearing completes.
  - MISALIGN is purely combinational and has no reset value.
  - State before the first RST is undefined; the top level must assert RST at power-up.
- test_value: always mem[TEST_ADDR][15:0], combinational, not gated by BUSY.

Test Plan:
- Clear: RST=1 for 2 cycles, then 0 -> BUSY high for exactly 256 cycles; afterwards LW at 0x000 and 0x3FC both return 0x00000000. Reassert RST at clear cycle 100 -> BUSY held a further 256 cycles.
- Byte lanes: SW 0x11223344 @0x010; SB 0xAB @0x012 -> LW @0x010 = 0x11AB3344. LB @0x012 = 0xFFFFFFAB. LBU @0x012 = 0x000000AB.
- Halfwords: SH 0x8001 @0x022 -> LW @0x020 = 0x80010000. LH @0x022 = 0xFFFF8001. LHU @0x022 = 0x00008001.
- Misalign: SW 0xDEADBEEF @0x031 -> MISALIGN=1 and word 0x030 unchanged. LH @0x033 -> MISALIGN=1, RD=0. SIZE=11 -> MISALIGN=1.
- Wrap: SW 0xCAFEF00D @0x400 (DEPTH=256) -> LW @0x000 = 0xCAFEF00D; test_value = 0xF00D.
- BUSY gating: SW 0x12345678 @0x040 issued during clear -> after BUSY falls, LW @0x040 = 0x00000000.
